// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: op encodings, decode, lane helpers
// and the access FSM state type.
package mem_pkg;

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;

  typedef enum logic [1:0] {SIZE_B = 2'd0, SIZE_H = 2'd1, SIZE_W = 2'd2} size_e;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  typedef struct packed {
    logic  legal;
    logic  is_store;
    logic  is_unsigned;
    size_e size;
  } op_info_t;

  function automatic op_info_t decode_op(input logic [3:0] op);
    op_info_t info;
    info.is_store    = op[3];
    info.is_unsigned = op[2];
    case (op[1:0])
      2'b00:   info.size = SIZE_B;
      2'b01:   info.size = SIZE_H;
      default: info.size = SIZE_W;
    endcase
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: info.legal = 1'b1;
      default: info.legal = 1'b0;
    endcase
    return info;
  endfunction

  function automatic logic [3:0] byte_en(input size_e size, input logic [1:0] lane);
    case (size)
      SIZE_B:  return 4'b0001 << lane;
      SIZE_H:  return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input size_e size, input logic [1:0] lane);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return lane[0];
      default: return lane != 2'b00;
    endcase
  endfunction

  // Replicate the store operand across every lane so the byte enables alone pick the target.
  function automatic logic [31:0] store_data(input size_e size, input logic [31:0] wdata);
    case (size)
      SIZE_B:  return {4{wdata[7:0]}};
      SIZE_H:  return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Extracts the addressed byte/half from a read word and sign- or zero-extends it.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  addr_lo,
  input  size_e       size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    byte_sel = mem_rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    result   = mem_rdata;
    case (size)
      SIZE_B:  result = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SIZE_H:  result = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      default: result = mem_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MIPS byte/half/word load-store stage over a req/gnt/rvalid bus, with
// alignment checking, bus-timeout and pipeline stall.
module load_store_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        mem_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_error,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_err
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_e      state;
  op_info_t    dec;
  logic        reject;
  logic [1:0]  lane_q;
  size_e       size_q;
  logic        unsigned_q;
  logic        store_q;
  logic [7:0]  wait_cnt;
  logic [31:0] load_data;

  assign dec       = decode_op(mem_op);
  assign reject    = ~dec.legal | misaligned(dec.size, addr[1:0]);
  assign req_ready = (state == IDLE);
  assign busy      = ~req_ready;

  mem_load_align u_align (
    .mem_rdata   (mem_rdata),
    .addr_lo     (lane_q),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .result      (load_data)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lane_q     <= 2'b00;
      size_q     <= SIZE_B;
      unsigned_q <= 1'b0;
      store_q    <= 1'b0;
      wait_cnt   <= 8'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= 4'b0000;
      mem_wdata  <= 32'd0;
      rsp_valid  <= 1'b0;
      rsp_error  <= 1'b0;
      rsp_rdata  <= 32'd0;
    end else begin
      unique case (state)
        IDLE: if (req_valid) begin
          lane_q     <= addr[1:0];
          size_q     <= dec.size;
          unsigned_q <= dec.is_unsigned;
          store_q    <= dec.is_store;
          mem_addr   <= {addr[ADDR_W-1:2], 2'b00};
          mem_be     <= dec.legal ? byte_en(dec.size, addr[1:0]) : 4'b0000;
          mem_wdata  <= store_data(dec.size, wdata);
          mem_we     <= dec.legal & dec.is_store;
          if (reject) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_error <= 1'b1;
            rsp_rdata <= 32'd0;
          end else begin
            state   <= ISSUE;
            mem_req <= 1'b1;
          end
        end
        ISSUE: if (mem_gnt) begin
          mem_req <= 1'b0;
          if (mem_rvalid) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_error <= mem_err;
            rsp_rdata <= (mem_err | store_q) ? 32'd0 : load_data;
          end else begin
            state    <= WAIT;
            wait_cnt <= 8'd0;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_error <= mem_err;
            rsp_rdata <= (mem_err | store_q) ? 32'd0 : load_data;
          end else if (wait_cnt + 8'd1 == TIMEOUT_CNT) begin
            // Hung access: give up and report an error rather than stall forever.
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_error <= 1'b1;
            rsp_rdata <= 32'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_error <= 1'b0;
          rsp_rdata <= 32'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stimulus pushes expected responses into a
// queue, a negedge monitor pops and compares each rsp_valid pulse.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  load_store_unit #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .mem_op     (mem_op),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: every rsp_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_error", {31'd0, rsp_error}, {31'd0, e.err});
        if (e.cyc >= 0) check("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  // Presents one access at a negedge; returns at the negedge after the accept edge.
  // lat = cycles from the cycle after accept to rsp_valid, or -1 for "don't care".
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_er, input int lat,
                       input bit push);
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_before_issue", {31'd0, req_ready}, 32'd1);
    if (push) exp_q.push_back('{exp_rd, exp_er, (lat < 0) ? -1 : cyc + 1 + lat});
    req_valid = 1'b1;
    mem_op    = op;
    addr      = a;
    wdata     = wd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Memory side: checks the request, withholds gnt for gnt_wait cycles, then
  // answers rv_wait cycles after the grant (0 = same cycle as the grant).
  task automatic run_mem(input int gnt_wait, input int rv_wait, input bit respond,
                         input logic [31:0] rd, input logic er,
                         input logic [31:0] e_addr, input logic [3:0] e_be,
                         input logic [31:0] e_wd, input logic e_we);
    int n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mem_req_seen", {31'd0, mem_req}, 32'd1);
    check("mem_addr", mem_addr, e_addr);
    check("mem_be", {28'd0, mem_be}, {28'd0, e_be});
    check("mem_wdata", mem_wdata, e_wd);
    check("mem_we", {31'd0, mem_we}, {31'd0, e_we});
    check("busy_in_issue", {31'd0, busy}, 32'd1);
    for (int i = 0; i < gnt_wait; i++) begin
      @(negedge clk);
      check("mem_req_held", {31'd0, mem_req}, 32'd1);
      check("mem_addr_stable", mem_addr, e_addr);
    end
    mem_gnt = 1'b1;
    if (respond && rv_wait == 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rd;
      mem_err    = er;
    end
    @(negedge clk);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_err    = 1'b0;
    check("mem_req_dropped", {31'd0, mem_req}, 32'd0);
    if (respond && rv_wait > 0) begin
      repeat (rv_wait - 1) @(negedge clk);
      mem_rvalid = 1'b1;
      mem_rdata  = rd;
      mem_err    = er;
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_err    = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    mem_op     = 4'b0000;
    addr       = 32'd0;
    wdata      = 32'd0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    mem_err    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_mem_req", {31'd0, mem_req}, 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    // LW zero-wait: response in the second cycle after accept
    issue(4'b0010, 32'h100, 32'd0, 32'hDEADBEEF, 1'b0, 1, 1'b1);
    run_mem(0, 0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h100, 4'b1111, 32'd0, 1'b0);
    drain("drain_lw");

    // LB / LBU on the top lane
    issue(4'b0000, 32'h103, 32'd0, 32'hFFFFFF80, 1'b0, 1, 1'b1);
    run_mem(0, 0, 1'b1, 32'h80123456, 1'b0, 32'h100, 4'b1000, 32'd0, 1'b0);
    drain("drain_lb");
    issue(4'b0100, 32'h103, 32'd0, 32'h00000080, 1'b0, 1, 1'b1);
    run_mem(0, 0, 1'b1, 32'h80123456, 1'b0, 32'h100, 4'b1000, 32'd0, 1'b0);
    drain("drain_lbu");

    // LH upper half sign-extended, LHU lower half zero-extended
    issue(4'b0001, 32'h202, 32'd0, 32'hFFFF8001, 1'b0, -1, 1'b1);
    run_mem(1, 1, 1'b1, 32'h80015555, 1'b0, 32'h200, 4'b1100, 32'd0, 1'b0);
    drain("drain_lh");
    issue(4'b0101, 32'h000, 32'd0, 32'h0000F00D, 1'b0, -1, 1'b1);
    run_mem(0, 3, 1'b1, 32'h1234F00D, 1'b0, 32'h000, 4'b0011, 32'd0, 1'b0);
    drain("drain_lhu");

    // SH with slow grant and delayed ack; store returns zero data
    issue(4'b1001, 32'h102, 32'h1234BEEF, 32'd0, 1'b0, -1, 1'b1);
    run_mem(2, 2, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h100, 4'b1100, 32'hBEEFBEEF, 1'b1);
    drain("drain_sh");

    // SB and SW lane replication
    issue(4'b1000, 32'h101, 32'h000000AB, 32'd0, 1'b0, 1, 1'b1);
    run_mem(0, 0, 1'b1, 32'h55555555, 1'b0, 32'h100, 4'b0010, 32'hABABABAB, 1'b1);
    drain("drain_sb");
    issue(4'b1010, 32'h008, 32'hCAFEF00D, 32'd0, 1'b0, -1, 1'b1);
    run_mem(1, 1, 1'b1, 32'd0, 1'b0, 32'h008, 4'b1111, 32'hCAFEF00D, 1'b1);
    drain("drain_sw");

    // Bus error on a load: error flagged, data forced to zero
    issue(4'b0010, 32'h010, 32'd0, 32'd0, 1'b1, -1, 1'b1);
    run_mem(0, 1, 1'b1, 32'h12345678, 1'b1, 32'h010, 4'b1111, 32'd0, 1'b0);
    drain("drain_buserr");

    // Misaligned LW and illegal op: immediate error, no bus traffic
    issue(4'b0010, 32'h101, 32'd0, 32'd0, 1'b1, 0, 1'b1);
    check("misal_no_req", {31'd0, mem_req}, 32'd0);
    check("misal_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("misal_ready_n2", {31'd0, req_ready}, 32'd1);
    check("misal_no_req_n2", {31'd0, mem_req}, 32'd0);
    issue(4'b0111, 32'h100, 32'd0, 32'd0, 1'b1, 0, 1'b1);
    check("illegal_no_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    check("illegal_ready_n2", {31'd0, req_ready}, 32'd1);
    drain("drain_bad");

    // Timeout: granted, never answered; 4 WAIT cycles then error
    issue(4'b0010, 32'h200, 32'd0, 32'd0, 1'b1, 5, 1'b1);
    run_mem(0, 0, 1'b0, 32'd0, 1'b0, 32'h200, 4'b1111, 32'd0, 1'b0);
    drain("drain_timeout");
    check("timeout_idle", {31'd0, req_ready}, 32'd1);

    // Reset while waiting, then a stray rvalid must be ignored
    issue(4'b0010, 32'h300, 32'd0, 32'd0, 1'b0, -1, 1'b0);
    run_mem(0, 0, 1'b0, 32'd0, 1'b0, 32'h300, 4'b1111, 32'd0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_be", {28'd0, mem_be}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBAD0BAD0;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("stray_no_rsp", {31'd0, rsp_valid}, 32'd0);
    check("stray_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    check("stray_no_rsp2", {31'd0, rsp_valid}, 32'd0);

    issue(4'b0010, 32'h104, 32'd0, 32'h0BADF00D, 1'b0, 1, 1'b1);
    run_mem(0, 0, 1'b1, 32'h0BADF00D, 1'b0, 32'h104, 4'b1111, 32'd0, 1'b0);
    drain("drain_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU: consumes the ALU result as effective address plus the rt value as store data, and performs MIPS byte/half/word loads and stores over a simple req/gnt/rvalid memory bus.
- Handles lane alignment, byte enables and load sign/zero extension, checks alignment, times out hung accesses, and drives busy to stall the pipeline.

Parameters:
- ADDR_W, 32, byte-address width of addr and mem_addr.
- TIMEOUT, 255, max cycles in WAIT before a bus-timeout error; legal range 1..255 (8-bit counter).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  pipeline presents an access
- req_ready  out  1  unit idle and accepting
- mem_op  in  4  0000 LB, 0001 LH, 0010 LW, 0100 LBU, 0101 LHU, 1000 SB, 1001 SH, 1010 SW; all others illegal
- addr  in  ADDR_W  effective byte address (ALU result)
- wdata  in  32  store data (rt)
- busy  out  1  pipeline stall, equals ~req_ready
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_error  out  1  misaligned, illegal op, bus error or timeout; valid with rsp_valid
- mem_req  out  1  bus request, held until mem_gnt
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word address; bits [1:0] always 00
- mem_be  out  4  byte enables; lane i = bits [8i+7:8i]; little-endian
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  read data / write ack
- mem_rdata  in  32  read word
- mem_err  in  1  bus error, qualified by mem_rvalid

Behaviour:
- Reset: state IDLE; mem_req, mem_we, rsp_valid, rsp_error = 0; rsp_rdata, mem_addr, mem_be, mem_wdata, timeout counter = 0. req_ready = 1 from the first cycle after reset deasserts.
- Accept when req_valid & req_ready at edge N. op, addr[1:0], mem_addr, mem_be and mem_wdata are registered at N.
- Alignment checks: LH/LHU/SH need addr[0] = 0; LW/SW need addr[1:0] = 00. A misaligned or illegal op goes IDLE -> RESP, with rsp_valid and rsp_error = 1 in cycle N+1. mem_req never asserts.
- FSM states:
  - IDLE -> ISSUE on a legal accept.
  - ISSUE: mem_req = 1; address, we, be and wdata stay stable until mem_gnt. If mem_gnt & mem_rvalid in the same cycle (zero-wait memory) -> RESP. If mem_gnt only -> WAIT.
  - WAIT: mem_req = 0; counter increments each cycle. mem_rvalid -> RESP. Counter reaching TIMEOUT -> RESP with rsp_error = 1.
  - RESP: rsp_valid = 1 for exactly one cycle, then IDLE. No accept during RESP.
- Minimum legal latency: accept N, ISSUE N+1 with gnt and rvalid, rsp_valid N+2.
- mem_rvalid is ignored in IDLE, in RESP, and in ISSUE without gnt.
- Stores: SB sets mem_be = 0001 << addr[1:0] and mem_wdata = 4 copies of wdata[7:0]. SH sets mem_be = addr[1] ? 1100 : 0011 and mem_wdata = 2 copies of wdata[15:0]. SW sets mem_be = 1111 and mem_wdata = wdata. On completion rsp_rdata = 0.
- Loads: mem_we = 0 and mem_be follows the same lane rule as stores. Extract the lane selected by addr[1:0] (byte) or addr[1] (half). LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- mem_err with mem_rvalid: rsp_error = 1 and rsp_rdata = 0.
- Reset mid-operation: next edge returns to IDLE and drops mem_req. A later stray mem_rvalid is ignored.
- busy is asserted from the cycle after accept through the RESP cycle inclusive.

Decomposition:
- Shared package mem_pkg holds:
  - mem_op encodings and an is_store/is_unsigned/size decode function.
  - FSM state enum {IDLE, ISSUE, WAIT, RESP}.
  - Byte-enable helper.
- One combinational sub-module, mem_load_align: inputs mem_rdata, addr[1:0], size, is_unsigned; output the extended 32-bit result.

Test Plan:
- LW at addr 0x100, memory answers gnt & rvalid in ISSUE with rdata 0xDEADBEEF -> mem_addr 0x100, mem_be 1111; rsp_valid at N+2 with rsp_rdata 0xDEADBEEF, rsp_error 0.
- LB and LBU at addr 0x103, mem_rdata 0x80123456 -> mem_addr 0x100, mem_be 1000; LB gives 0xFFFFFF80, LBU gives 0x00000080.
- SH at addr 0x102 with wdata 0x1234BEEF, gnt after 3 cycles, rvalid 2 cycles later -> mem_req held 3 cycles; mem_we 1, mem_be 1100, mem_wdata 0xBEEFBEEF; single rsp_valid, rsp_rdata 0.
- LW at addr 0x101; separately mem_op 0111 -> rsp_valid & rsp_error at N+1; mem_req never asserts; req_ready returns to 1 at N+2.
- LW granted but mem_rvalid never arrives, TIMEOUT = 4 -> rsp_error = 1 after 4 WAIT cycles; unit returns to IDLE.
- Reset asserted in WAIT, then mem_rvalid pulses in IDLE -> no rsp_valid; req_ready = 1, all outputs 0; next LW completes normally.
